// File: rtl/eth_parser_input_arbiter.sv
// Frame-level arbiter feeding a single ethernet_frame_parser AXI4-Stream input.
// One ingress stream is granted at a time. The grant is held until that stream's tlast
// beat is accepted, and the granted index is presented on m_axis_tid for the whole frame.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   s_axis_*       NUM_PORTS ingress streams; port i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*       single egress stream towards the parser, plus m_axis_tid source index
//   busy           high while a grant is held
//
// Build option: define ETH_ARB_STRICT_PRIO_EN for strict lowest-index-wins priority;
// by default arbitration is round-robin.
module eth_parser_input_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_W       = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_W-1:0]                 m_axis_tid,
  output logic                            busy
);

  typedef enum logic [0:0] {StIdle, StPass} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic            win_valid;
  logic [ID_W-1:0] win_idx;

`ifdef ETH_ARB_STRICT_PRIO_EN
  // Lowest-index requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!win_valid && s_axis_tvalid[k]) begin
        win_valid = 1'b1;
        win_idx   = ID_W'(k);
      end
    end
  end
`else
  localparam int unsigned CW = ID_W + 1;

  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      start_idx;
  logic [NUM_PORTS-1:0] req_rot;
  logic [CW-1:0]        cand;

  // Rotate the request vector so bit 0 is the port after the last winner, then take the
  // first set bit. The wrap back to a port index is an explicit subtract, so non-power-of-two
  // port counts work.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (last_grant_q == ID_W'(NUM_PORTS - 1)) begin
      start_idx = '0;
    end else begin
      start_idx = last_grant_q + 1'b1;
    end
    req_rot = NUM_PORTS'({s_axis_tvalid, s_axis_tvalid} >> start_idx);
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!win_valid && req_rot[k]) begin
        win_valid = 1'b1;
        cand      = {1'b0, start_idx} + CW'(k);
        if (cand >= CW'(NUM_PORTS)) begin
          cand = cand - CW'(NUM_PORTS);
        end
        win_idx = cand[ID_W-1:0];
      end
    end
  end

  assign last_grant_d = (state_q == StIdle && win_valid) ? win_idx : last_grant_q;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StPass;
          grant_d = win_idx;
        end
      end
      StPass: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifndef ETH_ARB_STRICT_PRIO_EN
  // Reset to the last port so port 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_PORTS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Zero-latency mux from the registered grant; everything is quiet in IDLE.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == StPass) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (grant_q == ID_W'(k)) begin
          m_axis_tdata     = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tlast     = s_axis_tlast[k];
          m_axis_tvalid    = s_axis_tvalid[k];
          s_axis_tready[k] = m_axis_tready;
        end
      end
    end
  end

  assign m_axis_tid = grant_q;
  assign busy       = (state_q == StPass);

endmodule

// File: tb/tb_eth_parser_input_arbiter.sv
// Bench for eth_parser_input_arbiter: per-port frame sources, and a scoreboard of
// expected output beats held in grant order.
module tb_eth_parser_input_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tready;
  logic [NP-1:0]    s_tlast;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             busy;

  eth_parser_input_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .ID_W       (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .busy          (busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  logic [DW:0]   src_mem [NP][32];
  int            src_head [NP];
  int            src_tail [NP];
  logic [NP-1:0] acc = '0;
  logic          gap_pending = 1'b0;
  beat_t         exp_q [$];

  // Queue a frame on a source and push its beats onto the scoreboard.
  task automatic load_frame(input int port, input int nbeats);
    logic [DW-1:0] d;
    beat_t         e;
    for (int b = 0; b < nbeats; b++) begin
      d = {8'hA5, 8'(port), 16'h0, 32'(seq)};
      seq++;
      src_mem[port][src_tail[port] % 32] = {(b == nbeats - 1), d};
      src_tail[port]++;
      e.tid  = IW'(port);
      e.last = (b == nbeats - 1);
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NP; i++) src_head[i] = src_tail[i];
    exp_q.delete();
  endtask

  // Source driver: advance past accepted beats, present the next one.
  initial begin
    for (int i = 0; i < NP; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (acc[i]) src_head[i]++;
        if (src_head[i] < src_tail[i]) begin
          s_tvalid[i] = 1'b1;
          {s_tlast[i], s_tdata[i*DW +: DW]} = src_mem[i][src_head[i] % 32];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge.
  initial begin
    logic [NP-1:0] exp_rdy;
    beat_t         e;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      if (rst) begin
        gap_pending = 1'b0;
      end else begin
        if (gap_pending) begin
          n_checks++;
          if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap: got tvalid=%b busy=%b, expected 0 0", m_tvalid, busy);
          end
          gap_pending = 1'b0;
        end
        exp_rdy = busy ? (NP'(m_tready) << m_tid) : '0;
        n_checks++;
        if (s_tready !== exp_rdy) begin
          n_fail++;
          $display("FAIL ready: got %b expected %b", s_tready, exp_rdy);
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat: got unexpected tid=%0d data=%h", m_tid, m_tdata);
          end else begin
            e = exp_q.pop_front();
            if ({m_tid, m_tlast, m_tdata} !== e) begin
              n_fail++;
              $display("FAIL beat: got tid=%0d last=%b data=%h expected tid=%0d last=%b data=%h",
                       m_tid, m_tlast, m_tdata, e.tid, e.last, e.data);
            end
          end
          if (m_tlast === 1'b1) gap_pending = 1'b1;
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d beats outstanding, expected 0", name, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    flush_sources();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({busy, m_tvalid, m_tlast, m_tdata, m_tid, s_tready} !== '0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b tvalid=%b tlast=%b tdata=%h tid=%0d tready=%b, expected 0",
               name, busy, m_tvalid, m_tlast, m_tdata, m_tid, s_tready);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    m_tready = 1'b1;
    #3;
    check_idle_outputs("reset_held");
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_single_frame();
    do_reset();
    @(negedge clk);
    load_frame(0, 3);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_n: got %b expected 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || m_tid !== 2'd0 || m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got busy=%b tid=%0d tvalid=%b expected 1 0 1",
               busy, m_tid, m_tvalid);
    end
    wait_drain("single", 20);
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    load_frame(0, 1);
    load_frame(1, 1);
    load_frame(2, 1);
    load_frame(3, 1);
    load_frame(0, 1);
    load_frame(1, 1);
    wait_drain("round_robin", 40);
  endtask

  task automatic test_backpressure();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    load_frame(1, 4);
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      m_tready = pat[i];
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure: got %0d left busy=%b expected 0 0", exp_q.size(), busy);
    end
    m_tready = 1'b1;
    wait_drain("backpressure", 10);
  endtask

  task automatic test_no_preempt();
    // Grant history ends on port 1, so port 2 is searched from port 2 onward.
    @(negedge clk);
    load_frame(2, 4);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || m_tid !== 2'd2) begin
      n_fail++;
      $display("FAIL preempt_grant: got busy=%b tid=%0d expected 1 2", busy, m_tid);
    end
    load_frame(3, 1);
    load_frame(0, 1);
    wait_drain("preempt_a", 30);
    @(negedge clk);
    load_frame(2, 2);
    @(negedge clk);
    @(negedge clk);
    load_frame(0, 1);
    wait_drain("preempt_b", 30);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    @(negedge clk);
    load_frame(3, 5);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    n_checks++;
    if (m_tvalid !== 1'b1 || exp_q.size() == 0 || m_tdata !== exp_q[0].data) begin
      n_fail++;
      $display("FAIL midframe_beat2: got tvalid=%b data=%h", m_tvalid, m_tdata);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("midframe_reset");
    n_checks++;
    if (exp_q.size() != 4) begin
      n_fail++;
      $display("FAIL midframe_count: got %0d untransferred expected 4", exp_q.size());
    end
    flush_sources();
    @(negedge clk);
    load_frame(0, 1);
    load_frame(3, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_drain("midframe_restart", 20);
  endtask

  task automatic test_prio_mode();
    do_reset();
    @(negedge clk);
`ifdef ETH_ARB_STRICT_PRIO_EN
    load_frame(0, 1);
    load_frame(0, 1);
    load_frame(0, 1);
    load_frame(2, 1);
    load_frame(2, 1);
`else
    load_frame(0, 1);
    load_frame(2, 1);
    load_frame(0, 1);
    load_frame(2, 1);
    load_frame(0, 1);
`endif
    wait_drain("prio_mode", 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    m_tready = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_no_preempt();
    test_reset_midframe();
    test_prio_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
